mips_cpu_harvard_data_ram: RTL
==============================

Name: mips_cpu_harvard_data_ram

Overview:
Data-memory responder at the far end of the Harvard CPU data port. It consumes the mem_read/mem_write strobes produced by the control unit and the ALU-computed address, and services word accesses with byte enables and a configurable number of wait states. It reports completion with a one-cycle ack and holds the CPU off with busy. It detects misaligned or conflicting requests.

Parameters:
ADDR_WIDTH, 10, word-address bits; depth = 2**ADDR_WIDTH 32-bit words
WAIT_CYCLES, 2, extra cycles between request acceptance and ack; legal range 0..15

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
mem_read  input  1  read request strobe from control unit
mem_write  input  1  write request strobe from control unit
addr  input  32  byte address; bits [1:0] must be 00
write_data  input  32  store data
byte_en  input  4  per-byte write enable; byte_en[i] selects write_data[8i+7:8i]
read_data  output  32  load data, registered
ack  output  1  one-cycle completion pulse
err  output  1  one-cycle error pulse, coincident with ack
busy  output  1  high while a request is in flight; CPU stalls on it

Behaviour:
- Reset (rst_n low, asynchronous): state IDLE, wait counter 0, read_data 32'h0, ack 0, err 0, busy 0. Memory contents are not reset.
- States: IDLE, WAIT, RESP. busy = (state != IDLE), decoded from registered state.
- IDLE: at a rising edge with mem_read|mem_write high, latch addr, write_data, byte_en and op.
  - If WAIT_CYCLES = 0, go to RESP.
  - Otherwise go to WAIT with counter = WAIT_CYCLES-1.
  - With no request, stay in IDLE.
- WAIT: decrement the counter each cycle. At the edge where counter = 0, go to RESP and perform the access.
- Access (on the edge entering RESP):
  - Word index = latched addr[ADDR_WIDTH+1:2]. Upper address bits are ignored, so addresses wrap modulo depth.
  - Write: only bytes with byte_en set are updated. byte_en = 0000 is a legal no-op write.
  - Read: read_data loads the full word. read_data holds until the next successful read and is unchanged by writes and errors.
- RESP: ack = 1 for exactly one cycle, then IDLE.
- Latency: ack is high in the cycle that starts WAIT_CYCLES+1 edges after the accepting edge. Minimum spacing between accepted requests is WAIT_CYCLES+2 cycles.
- Requests are ignored while busy or in RESP. The CPU holds its strobes until it sees ack; a strobe still high in the cycle after ack starts a new access.
- Error cases, each going through the full WAIT/RESP sequence with ack=1 and err=1 in RESP:
  - Latched addr[1:0] != 00: no memory update and no read_data update.
  - mem_read and mem_write both high: no memory update and no read_data update.
- Read and write to the same word in consecutive transactions: the read returns the newly written data.
- Reset mid-operation (in WAIT): the pending access is abandoned and no write commits. Memory contents are retained. ack is not produced.
- err is only ever high together with ack.

Test Plan:
- Reset, then write 32'hDEADBEEF, byte_en 1111 at addr 0x10, then read 0x10 with WAIT_CYCLES=2 -> each ack arrives 3 edges after acceptance, busy high for 3 cycles; read_data = 32'hDEADBEEF in the read ack cycle.
- Write 32'h11223344 to 0x20, then write 32'hAABBCCDD with byte_en 0101, then read 0x20 -> read_data = 32'h11BB33DD.
- Read addr 0x22 (misaligned) -> ack and err together after WAIT_CYCLES+1 edges; read_data keeps its previous value; memory unchanged on reread of 0x20.
- mem_read and mem_write both high, addr 0x30 -> err pulse with ack; word 0x30 keeps its prior value.
- Assert rst_n low during WAIT of a write of 32'hCAFEF00D to 0x40 that previously held 32'h0 -> no ack, busy 0 immediately; a read of 0x40 after reset returns 32'h0.
- WAIT_CYCLES=0 build: back-to-back requests with strobes held -> ack every 2nd cycle. Write to addr 0x1000 with ADDR_WIDTH=10 aliases to 0x0 -> a read of 0x0 returns the written value.

Source files
------------

// File: rtl/mips_cpu_harvard_data_ram.sv
// mips_cpu_harvard_data_ram
//
// Data-memory responder on the Harvard CPU data port. It services 32-bit word
// accesses with per-byte write enables after a fixed number of wait states.
// A one-cycle ack_o marks completion, and busy_o holds the CPU off while a
// request is in flight. A request with a misaligned address, or with both
// strobes high, still runs the full wait sequence. It completes with err_o
// alongside ack_o and touches neither memory nor read_data_o.
//
// Parameters
//   ADDR_WIDTH   word-address bits, depth = 2**ADDR_WIDTH words
//   WAIT_CYCLES  extra cycles between acceptance and ack (0..15)
//
// Ports
//   clk           system clock, rising edge
//   rst_n         asynchronous active-low reset
//   mem_read_i    read request strobe
//   mem_write_i   write request strobe
//   addr_i        byte address, [1:0] must be 00
//   write_data_i  store data
//   byte_en_i     per-byte write enable
//   read_data_o   registered load data
//   ack_o         one-cycle completion pulse
//   err_o         one-cycle error pulse, only together with ack_o
//   busy_o        request in flight
//
// state | meaning
// ------+----------------------------------------------------------
// IDLE  | waiting for a strobe; a strobe at the edge is accepted
// WAIT  | counting down wait states; access happens when count is 0
// RESP  | ack_o (and err_o if faulted) high for this one cycle
module mips_cpu_harvard_data_ram #(
  parameter int ADDR_WIDTH  = 10,
  parameter int WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        mem_read_i,
  input  logic        mem_write_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] write_data_i,
  input  logic [3:0]  byte_en_i,
  output logic [31:0] read_data_o,
  output logic        ack_o,
  output logic        err_o,
  output logic        busy_o
);

  localparam int DEPTH = 1 << ADDR_WIDTH;
  localparam int AW    = ADDR_WIDTH + 2;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_WAIT = 2'd1;
  localparam logic [1:0] ST_RESP = 2'd2;

  localparam bit         ZERO_WAIT = (WAIT_CYCLES == 0);
  localparam logic [3:0] CNT_INIT  = ZERO_WAIT ? 4'd0 : 4'(WAIT_CYCLES - 1);

  logic [1:0]    state_q, state_d;
  logic [3:0]    cnt_q, cnt_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [31:0]   wdata_q, wdata_d;
  logic [3:0]    be_q, be_d;
  logic          rd_q, rd_d;
  logic          wr_q, wr_d;
  logic          err_q, err_d;
  logic [31:0]   rdata_q, rdata_d;

  logic [31:0]   mem_q [DEPTH];

  logic                  req;
  logic                  access;
  logic [AW-1:0]         acc_addr;
  logic [31:0]           acc_wdata;
  logic [3:0]            acc_be;
  logic                  acc_rd;
  logic                  acc_wr;
  logic                  acc_err;
  logic [ADDR_WIDTH-1:0] acc_idx;
  logic                  mem_we;

  // Address bits above the word index are ignored, so accesses wrap modulo depth.
  logic unused_addr_hi;
  assign unused_addr_hi = ^addr_i[31:AW];

  assign req = mem_read_i | mem_write_i;

  // The access happens on the edge that enters RESP. With zero wait states,
  // that edge is the accepting edge, so the live inputs are used instead of
  // the latched copy.
  always_comb begin
    if (state_q == ST_IDLE) begin
      acc_addr  = addr_i[AW-1:0];
      acc_wdata = write_data_i;
      acc_be    = byte_en_i;
      acc_rd    = mem_read_i;
      acc_wr    = mem_write_i;
    end else begin
      acc_addr  = addr_q;
      acc_wdata = wdata_q;
      acc_be    = be_q;
      acc_rd    = rd_q;
      acc_wr    = wr_q;
    end
  end

  assign acc_err = (acc_addr[1:0] != 2'b00) || (acc_rd && acc_wr);
  assign acc_idx = acc_addr[AW-1:2];
  assign mem_we  = access && !acc_err && acc_wr;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    be_d    = be_q;
    rd_d    = rd_q;
    wr_d    = wr_q;
    err_d   = err_q;
    rdata_d = rdata_q;
    access  = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (req) begin
          addr_d  = addr_i[AW-1:0];
          wdata_d = write_data_i;
          be_d    = byte_en_i;
          rd_d    = mem_read_i;
          wr_d    = mem_write_i;
          if (ZERO_WAIT) begin
            state_d = ST_RESP;
            access  = 1'b1;
          end else begin
            state_d = ST_WAIT;
            cnt_d   = CNT_INIT;
          end
        end
      end
      ST_WAIT: begin
        if (cnt_q == 4'd0) begin
          state_d = ST_RESP;
          access  = 1'b1;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      ST_RESP: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    if (access) begin
      err_d = acc_err;
      if (!acc_err && acc_rd) begin
        rdata_d = mem_q[acc_idx];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= 4'd0;
      addr_q  <= '0;
      wdata_q <= 32'h0;
      be_q    <= 4'h0;
      rd_q    <= 1'b0;
      wr_q    <= 1'b0;
      err_q   <= 1'b0;
      rdata_q <= 32'h0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      be_q    <= be_d;
      rd_q    <= rd_d;
      wr_q    <= wr_d;
      err_q   <= err_d;
      rdata_q <= rdata_d;
    end
  end

  // The storage has no reset, so its contents survive rst_n. A write abandoned
  // in WAIT never reaches this block because mem_we only fires on RESP entry.
  always_ff @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (mem_we && acc_be[i]) begin
        mem_q[acc_idx][8*i +: 8] <= acc_wdata[8*i +: 8];
      end
    end
  end

  assign busy_o      = (state_q != ST_IDLE);
  assign ack_o       = (state_q == ST_RESP);
  assign err_o       = (state_q == ST_RESP) && err_q;
  assign read_data_o = rdata_q;

endmodule
